// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one N-bit word per cycle, LSW first.
// Ports: i_clk, i_reset, i_start, i_sub, i_op_a, i_op_b, o_busy, o_done, o_sum, o_cout.

// N-bit adder with carry-out.
// Ports: a, b -> sum, carry.
module adder_carry #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

module adder_seq_ctrl #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [N*WORDS-1:0] i_op_a,
  input  logic [N*WORDS-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [N*WORDS-1:0] o_sum,
  output logic             o_cout
);

  localparam int W  = N * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          sub;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sum_q;
  logic          cout_q;

  logic [N-1:0]  a_w;
  logic [N-1:0]  b_w;
  logic [N-1:0]  b_x;
  logic [N-1:0]  cin_w;
  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic          c1;
  logic          c2;
  logic          wc;
  logic          last;

  // Word mux: pick the operand slice addressed by the counter.
  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (cnt == CW'(k)) begin
        a_w = op_a[k*N +: N];
        b_w = op_b[k*N +: N];
      end
    end
  end

  // Subtract is A + ~B + 1; the +1 enters as the initial carry.
  assign b_x = sub ? ~b_w : b_w;

  always_comb begin
    cin_w    = '0;
    cin_w[0] = carry;
  end

  adder_carry #(.N(N)) u_stage1 (
    .a     (a_w),
    .b     (b_x),
    .sum   (s1),
    .carry (c1)
  );

  adder_carry #(.N(N)) u_stage2 (
    .a     (s1),
    .b     (cin_w),
    .sum   (s2),
    .carry (c2)
  );

  // c1 and c2 are mutually exclusive, so OR is the true word carry.
  assign wc   = c1 | c2;
  assign last = (cnt == CW'(WORDS - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= S_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sub    <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            op_a  <= i_op_a;
            op_b  <= i_op_b;
            sub   <= i_sub;
            carry <= i_sub;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (cnt == CW'(k)) begin
              sum_q[k*N +: N] <= s2;
            end
          end
          carry <= wc;
          cnt   <= cnt + 1'b1;
          if (last) begin
            cout_q <= wc;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state != S_IDLE);
  assign o_done = (state == S_DONE);
  assign o_sum  = sum_q;
  assign o_cout = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: N=4/WORDS=4 and N=8/WORDS=1 instances
// checked against a wide-arithmetic reference model.
module tb_adder_seq_ctrl;

  logic        clk;
  logic        rst;

  logic        start0;
  logic        sub0;
  logic [15:0] a0;
  logic [15:0] b0;
  logic        busy0;
  logic        done0;
  logic [15:0] sum0;
  logic        cout0;

  logic        start1;
  logic        sub1;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic        busy1;
  logic        done1;
  logic [7:0]  sum1;
  logic        cout1;

  int n_checks;
  int n_fails;

  adder_seq_ctrl #(.N(4), .WORDS(4)) dut0 (
    .i_clk   (clk),
    .i_reset (rst),
    .i_start (start0),
    .i_sub   (sub0),
    .i_op_a  (a0),
    .i_op_b  (b0),
    .o_busy  (busy0),
    .o_done  (done0),
    .o_sum   (sum0),
    .o_cout  (cout0)
  );

  adder_seq_ctrl #(.N(8), .WORDS(1)) dut1 (
    .i_clk   (clk),
    .i_reset (rst),
    .i_start (start1),
    .i_sub   (sub1),
    .i_op_a  (a1),
    .i_op_b  (b1),
    .o_busy  (busy1),
    .o_done  (done1),
    .o_sum   (sum1),
    .o_cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: result modulo 2^w; cout is carry-out (add) or A>=B (sub).
  function automatic logic [32:0] ref_op(input logic s,
                                         input logic [31:0] a,
                                         input logic [31:0] b,
                                         input int w);
    logic [32:0] m;
    logic [32:0] r;
    logic        c;
    m = (33'd1 << w) - 33'd1;
    if (s) begin
      r = ({1'b0, a} - {1'b0, b}) & m;
      c = (a >= b);
    end else begin
      r = ({1'b0, a} + {1'b0, b});
      c = r[w];
      r = r & m;
    end
    return {c, r[31:0]};
  endfunction

  task automatic op0(input string tag, input logic s,
                     input logic [15:0] a, input logic [15:0] b,
                     input bit now);
    int lat;
    logic [32:0] e;
    if (!now) @(negedge clk);
    sub0 = s; a0 = a; b0 = b; start0 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (done0) begin
        lat = i;
        break;
      end
    end
    e = ref_op(s, {16'd0, a}, {16'd0, b}, 16);
    check({tag, "_lat"}, lat, 5);
    check({tag, "_sum"}, {16'd0, sum0}, e[31:0]);
    check({tag, "_cout"}, {31'd0, cout0}, {31'd0, e[32]});
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done0}, 32'd0);
  endtask

  task automatic op1(input string tag, input logic s,
                     input logic [7:0] a, input logic [7:0] b);
    int lat;
    logic [32:0] e;
    @(negedge clk);
    sub1 = s; a1 = a; b1 = b; start1 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1) begin
        lat = i;
        break;
      end
    end
    e = ref_op(s, {24'd0, a}, {24'd0, b}, 8);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_sum"}, {24'd0, sum1}, e[31:0]);
    check({tag, "_cout"}, {31'd0, cout1}, {31'd0, e[32]});
  endtask

  initial begin
    int seen;
    logic [32:0] e;
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    start0 = 0; sub0 = 0; a0 = '0; b0 = '0;
    start1 = 0; sub1 = 0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sum", {16'd0, sum0}, 0);
    check("rst_busy", {31'd0, busy0}, 0);
    check("rst_done", {31'd0, done0}, 0);
    check("rst_cout", {31'd0, cout0}, 0);

    op0("add1", 1'b0, 16'h1234, 16'h0FFF, 1'b0);
    check("add1_val", {16'd0, sum0}, 32'h2233);
    op0("add2", 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    check("add2_cout", {31'd0, cout0}, 1);
    op0("sub1", 1'b1, 16'h0005, 16'h0007, 1'b0);
    check("sub1_val", {16'd0, sum0}, 32'hFFFE);
    op0("sub2", 1'b1, 16'h0007, 16'h0005, 1'b0);
    check("sub2_val", {16'd0, sum0}, 32'h0002);

    // Async reset mid-cycle with a nonzero result held.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_sum", {16'd0, sum0}, 0);
    check("arst_cout", {31'd0, cout0}, 0);
    check("arst_busy", {31'd0, busy0}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Starts during RUN and DONE must be ignored.
    @(negedge clk);
    sub0 = 0; a0 = 16'h1111; b0 = 16'h2222; start0 = 1'b1;
    seen = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      sub0 = 1; a0 = 16'hABCD; b0 = 16'h0F0F; start0 = 1'b1;
      if (done0) begin
        seen = i;
        break;
      end
    end
    check("ign_lat", seen, 5);
    check("ign_sum", {16'd0, sum0}, 32'h3333);
    @(negedge clk);
    start0 = 1'b0;
    check("ign_busy", {31'd0, busy0}, 0);
    check("ign_sum2", {16'd0, sum0}, 32'h3333);

    // Back-to-back: restart in the idle cycle right after DONE.
    op0("b2b_a", 1'b0, 16'h00F0, 16'h0F00, 1'b1);
    op0("b2b_b", 1'b1, 16'h8000, 16'h0001, 1'b1);

    // Reset during word 2 aborts with no done.
    @(negedge clk);
    sub0 = 0; a0 = 16'h4444; b0 = 16'h5555; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy0}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done0) seen++;
    end
    check("abort_nodone", seen, 0);
    op0("post", 1'b0, 16'h0001, 16'h0001, 1'b0);
    check("post_val", {16'd0, sum0}, 32'h0002);

    // WORDS=1 instance.
    op1("w1", 1'b0, 8'hFF, 8'h01);
    check("w1_val", {24'd0, sum1}, 0);
    check("w1_cout", {31'd0, cout1}, 1);

    for (int k = 0; k < 25; k++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if (k % 5 == 0) rb = ra;
      op0("rnd0", rs, ra, rb, 1'($urandom));
    end
    for (int k = 0; k < 15; k++) begin
      op1("rnd1", 1'($urandom), 8'($urandom), 8'($urandom));
    end

    e = ref_op(1'b1, 32'h0, 32'h0, 16);
    check("ref_eq", {31'd0, e[32]}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
